// File: rtl/ctl_diag_seq_if.sv
// Diagnostic function bus: front-end strobe/function code, EBUS read handshake,
// and decoded load/read enables with status back to the front end.
interface ctl_diag_seq_if #(
  parameter int NGRP   = 16,
  parameter int DATA_W = 36
);
  logic              diagStrobe;
  logic [0:6]        diagFunc;
  logic              ebusXfer;
  logic [0:DATA_W-1] ebusData;
  logic              clrErr;
  logic [0:NGRP-1]   ldPulse;
  logic [0:NGRP-1]   rdEn;
  logic              ebusDrive;
  logic [0:DATA_W-1] rdData;
  logic              done;
  logic              busy;
  logic              timeoutErr;
  logic              badFunc;

  modport master (
    output diagStrobe, diagFunc, ebusXfer, ebusData, clrErr,
    input  ldPulse, rdEn, ebusDrive, rdData, done, busy, timeoutErr, badFunc
  );

  modport slave (
    input  diagStrobe, diagFunc, ebusXfer, ebusData, clrErr,
    output ldPulse, rdEn, ebusDrive, rdData, done, busy, timeoutErr, badFunc
  );
endinterface

// File: rtl/ctl_diag_seq.sv
// Diagnostic function sequencer: one synchronized strobe edge runs exactly one write pulse or EBUS read.
// Write ldPulse appears 3 cycles after the synchronized edge; reads wait up to TIMEOUT cycles for ebusXfer.
module ctl_diag_seq #(
  parameter int NGRP        = 16,
  parameter int DATA_W      = 36,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  ctl_diag_seq_if.slave   bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_PULSE   = 3'd2;
  localparam logic [2:0] ST_RDWAIT  = 3'd3;
  localparam logic [2:0] ST_RDHOLD  = 3'd4;
  localparam logic [2:0] ST_WAITREL = 3'd5;

  localparam logic [4:0] NGRP_L  = 5'(NGRP);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   edge_q, edge_d;
  logic [2:0]             state_q, state_d;
  logic [0:6]             func_q, func_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [0:DATA_W-1]      rd_data_q, rd_data_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   bad_func_q, bad_func_d;

  logic                   sync_out;
  logic                   vld_full;
  logic [3:0]             grp;
  logic                   grp_bad;
  logic                   set_to;
  logic                   set_bad;
  logic                   done_c;
  logic [0:NGRP-1]        ld_pulse;
  logic [0:NGRP-1]        rd_en;
  logic                   rd_act;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign vld_full = vld_q[SYNC_STAGES-1];
  assign grp      = func_q[0:3];
  assign grp_bad  = {1'b0, grp} >= NGRP_L;
  assign rd_act   = (state_q == ST_RDWAIT) || (state_q == ST_RDHOLD);

  // armed only after the chain holds real samples and has seen the strobe low,
  // so a strobe still high across reset is not mistaken for a fresh edge
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], bus.diagStrobe};
    vld_d         = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_d        = sync_out;
    armed_d       = armed_q | (vld_full & ~sync_out);
    edge_d        = armed_q & sync_out & ~prev_q;
    timeout_err_d = set_to  | (timeout_err_q & ~bus.clrErr);
    bad_func_d    = set_bad | (bad_func_q & ~bus.clrErr);
  end

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    set_to    = 1'b0;
    set_bad   = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_q) begin
          func_d  = bus.diagFunc;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (grp_bad) begin
          set_bad = 1'b1;
          done_c  = 1'b1;
          state_d = ST_WAITREL;
        end else if (!func_q[0]) begin
          state_d = ST_PULSE;
        end else begin
          cnt_d   = '0;
          state_d = ST_RDWAIT;
        end
      end
      ST_PULSE: begin
        done_c  = 1'b1;
        state_d = ST_WAITREL;
      end
      ST_RDWAIT: begin
        // an acknowledge on the final allowed cycle still completes the read
        if (bus.ebusXfer) begin
          rd_data_d = bus.ebusData;
          state_d   = ST_RDHOLD;
        end else if (cnt_q == TO_LAST) begin
          set_to  = 1'b1;
          done_c  = 1'b1;
          state_d = ST_WAITREL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RDHOLD: begin
        done_c  = 1'b1;
        state_d = ST_WAITREL;
      end
      ST_WAITREL: begin
        if (!sync_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_pulse = '0;
    rd_en    = '0;
    for (int i = 0; i < NGRP; i++) begin
      ld_pulse[i] = (state_q == ST_PULSE) && (grp == 4'(i));
      rd_en[i]    = rd_act && (grp == 4'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      vld_q         <= '0;
      prev_q        <= 1'b0;
      armed_q       <= 1'b0;
      edge_q        <= 1'b0;
      state_q       <= ST_IDLE;
      func_q        <= '0;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      timeout_err_q <= 1'b0;
      bad_func_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      vld_q         <= vld_d;
      prev_q        <= prev_d;
      armed_q       <= armed_d;
      edge_q        <= edge_d;
      state_q       <= state_d;
      func_q        <= func_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      timeout_err_q <= timeout_err_d;
      bad_func_q    <= bad_func_d;
    end
  end

  assign bus.ldPulse    = ld_pulse;
  assign bus.rdEn       = rd_en;
  assign bus.ebusDrive  = rd_act;
  assign bus.rdData     = rd_data_q;
  assign bus.done       = done_c;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.timeoutErr = timeout_err_q;
  assign bus.badFunc    = bad_func_q;

endmodule
